alarm_action_scheduler: RTL and testbench

//  Clocked front end for the AlarmSystem FSM. Merges user commands (close/open/lock/unlock)

---
 rtl/alarm_pkg.sv | 57 +++++
 rtl/alarm_sec_timer.sv | 65 ++++++
 rtl/alarm_action_scheduler.sv | 104 ++++++++++
 tb/tb_alarm_action_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// ============================================================================
// Module : alarm_pkg
// Brief  : Action/state codes and phase helpers for the alarm action scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

  typedef enum logic [2:0] {
    ACT_CLOSE   = 3'd0,
    ACT_OPEN    = 3'd1,
    ACT_LOCK    = 3'd2,
    ACT_UNLOCK  = 3'd3,
    ACT_WAIT20  = 3'd4,
    ACT_WAIT30  = 3'd5,
    ACT_WAIT270 = 3'd6,
    ACT_IDLE    = 3'd7
  } action_e;

  typedef enum logic [2:0] {
    ST_OPEN_UNLOCKED   = 3'd0,
    ST_OPEN_LOCKED     = 3'd1,
    ST_CLOSED_UNLOCKED = 3'd2,
    ST_CLOSED_LOCKED   = 3'd3,
    ST_ARMED           = 3'd4,
    ST_ARMED_FS        = 3'd5,
    ST_ARMED_FLASH     = 3'd6,
    ST_ILLEGAL         = 3'd7
  } state_e;

  function automatic logic is_timed(input logic [2:0] s);
    return (s == ST_CLOSED_LOCKED) || (s == ST_ARMED_FS) || (s == ST_ARMED_FLASH);
  endfunction

  function automatic logic [2:0] phase_event(input logic [2:0] s);
    case (s)
      ST_CLOSED_LOCKED: return ACT_WAIT20;
      ST_ARMED_FS:      return ACT_WAIT30;
      ST_ARMED_FLASH:   return ACT_WAIT270;
      default:          return ACT_IDLE;
    endcase
  endfunction

  function automatic int phase_secs(input logic [2:0] s, input int t_arm,
                                    input int t_sound, input int t_flash);
    case (s)
      ST_CLOSED_LOCKED: return t_arm;
      ST_ARMED_FS:      return t_sound;
      ST_ARMED_FLASH:   return t_flash;
      default:          return 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_sec_timer.sv
// ============================================================================
// Module : alarm_sec_timer
// Brief  : Per-second prescaler plus down-counter with a one-cycle expire pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_sec_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SEC_W         = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [SEC_W-1:0] i_load_val,
  input  logic             i_stop,
  output logic             o_busy,
  output logic [SEC_W-1:0] o_secs_left,
  output logic             o_expire
);

  localparam int PRE_W = $clog2(TICKS_PER_SEC);

  logic [PRE_W-1:0] r_pre;
  logic [SEC_W-1:0] r_secs;
  logic             r_busy;
  logic             w_wrap;

  assign w_wrap      = r_busy && (r_pre == PRE_W'(TICKS_PER_SEC - 1));
  // Expire is combinational so the event can be issued on the very edge the count hits zero.
  assign o_expire    = w_wrap && (r_secs <= SEC_W'(1)) && !i_load && !i_stop;
  assign o_busy      = r_busy;
  assign o_secs_left = r_secs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_secs <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_pre  <= '0;
      r_secs <= i_load_val;
      r_busy <= 1'b1;
    end else if (i_stop) begin
      r_pre  <= '0;
      r_secs <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      if (w_wrap) begin
        r_pre <= '0;
        if (r_secs != '0) begin
          r_secs <= r_secs - SEC_W'(1);
        end
        if (r_secs <= SEC_W'(1)) begin
          r_busy <= 1'b0;
        end
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alarm_action_scheduler.sv
// ============================================================================
// Module : alarm_action_scheduler
// Brief  : Merges user commands and timed alarm events into one paced action stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_action_scheduler
  import alarm_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int T_ARM         = 20,
  parameter int T_SOUND       = 30,
  parameter int T_FLASH       = 270,
  parameter int SEC_W         = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic [2:0]       fsm_state,
  output logic [2:0]       action,
  output logic             action_valid,
  output logic             timer_busy,
  output logic [SEC_W-1:0] secs_left
);

  typedef enum logic [0:0] {
    S_FREE  = 1'b0,
    S_ISSUE = 1'b1
  } slot_e;

  slot_e      r_slot, w_next_slot;
  logic [2:0] r_action, w_next_action;
  logic       r_pending, w_next_pending;
  logic [2:0] r_phase;
  logic [2:0] r_prev;

  logic             w_change, w_load, w_stop, w_expire, w_pend_ok;
  logic [SEC_W-1:0] w_load_val;

  assign w_change   = (fsm_state != r_prev);
  assign w_load     = w_change && is_timed(fsm_state);
  assign w_stop     = w_change && !is_timed(fsm_state);
  assign w_load_val = SEC_W'(phase_secs(fsm_state, T_ARM, T_SOUND, T_FLASH));
  // A timer event only goes out while the FSM still sits in the phase that produced it.
  assign w_pend_ok  = (r_pending || w_expire) && !w_change && (fsm_state == r_phase);

  alarm_sec_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .SEC_W         (SEC_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .i_stop      (w_stop),
    .o_busy      (timer_busy),
    .o_secs_left (secs_left),
    .o_expire    (w_expire)
  );

  always_comb begin
    w_next_slot    = S_FREE;
    w_next_action  = ACT_IDLE;
    w_next_pending = (r_pending || w_expire) && !w_change;
    if (r_slot == S_FREE) begin
      if (cmd_valid) begin
        w_next_slot   = S_ISSUE;
        w_next_action = {1'b0, cmd};
      end else if (w_pend_ok) begin
        w_next_slot    = S_ISSUE;
        w_next_action  = phase_event(r_phase);
        w_next_pending = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot    <= S_FREE;
      r_action  <= ACT_IDLE;
      r_pending <= 1'b0;
      r_phase   <= '0;
      r_prev    <= '0;
    end else begin
      r_slot    <= w_next_slot;
      r_action  <= w_next_action;
      r_pending <= w_next_pending;
      r_prev    <= fsm_state;
      if (w_load) begin
        r_phase <= fsm_state;
      end
    end
  end

  assign action       = r_action;
  assign action_valid = (r_slot == S_ISSUE);
  assign cmd_ready    = (r_slot == S_FREE);

endmodule

`default_nettype wire

// File: tb/tb_alarm_action_scheduler.sv
// ============================================================================
// Module : tb_alarm_action_scheduler
// Brief  : Directed bench with an alarm FSM model closing the loop on the scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_action_scheduler;

  localparam int TPS   = 4;
  localparam int SEC_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd = 2'd0;
  logic             cmd_ready;
  logic [2:0]       fsm_state = 3'd0;
  logic [2:0]       action;
  logic             action_valid;
  logic             timer_busy;
  logic [SEC_W-1:0] secs_left;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alarm_action_scheduler #(
    .TICKS_PER_SEC (TPS),
    .T_ARM         (2),
    .T_SOUND       (3),
    .T_FLASH       (5),
    .SEC_W         (SEC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_ready    (cmd_ready),
    .fsm_state    (fsm_state),
    .action       (action),
    .action_valid (action_valid),
    .timer_busy   (timer_busy),
    .secs_left    (secs_left)
  );

  function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic [2:0] a);
    case (s)
      3'd0: return (a == 3'd0) ? 3'd2 : (a == 3'd2) ? 3'd1 : s;
      3'd1: return (a == 3'd3) ? 3'd0 : (a == 3'd0) ? 3'd3 : s;
      3'd2: return (a == 3'd1) ? 3'd0 : (a == 3'd2) ? 3'd3 : s;
      3'd3: return (a == 3'd3) ? 3'd2 : (a == 3'd1) ? 3'd1 : (a == 3'd4) ? 3'd4 : s;
      3'd4: return (a == 3'd3) ? 3'd2 : (a == 3'd1) ? 3'd5 : s;
      3'd5: return (a == 3'd3) ? 3'd0 : (a == 3'd5) ? 3'd6 : s;
      3'd6: return (a == 3'd3) ? 3'd0 : (a == 3'd6) ? 3'd4 : s;
      default: return s;
    endcase
  endfunction

  // One clock: the FSM model latches whatever action was on the bus during this cycle.
  task automatic tick();
    logic       av;
    logic [2:0] a;
    av = action_valid;
    a  = action;
    @(posedge clk);
    #1;
    if (av) fsm_state = fsm_next(fsm_state, a);
  endtask

  // Offer one command, then spend the gap cycle; the model state is updated on return.
  task automatic issue_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({action, action_valid, cmd_ready, timer_busy} !== {3'd7, 1'b0, 1'b1, 1'b0} || secs_left !== '0) begin
      n_fail++;
      $display("FAIL reset_values act=%0d av=%0b rdy=%0b busy=%0b secs=%0d want 7 0 1 0 0",
               action, action_valid, cmd_ready, timer_busy, secs_left);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_close_lock_arm();
    cmd_valid = 1'b1;
    cmd       = 2'd0;
    tick();
    n_tests++;
    if (action !== 3'd0 || action_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL close_issue act=%0d av=%0b rdy=%0b want 0 1 0", action, action_valid, cmd_ready);
    end
    cmd = 2'd2;
    tick();
    n_tests++;
    if (action !== 3'd7 || action_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL close_gap act=%0d av=%0b rdy=%0b want 7 0 1", action, action_valid, cmd_ready);
    end
    tick();
    n_tests++;
    if (action !== 3'd2 || action_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_issue act=%0d av=%0b want 2 1", action, action_valid);
    end
    cmd_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if (timer_busy !== 1'b1 || secs_left !== 9'd2) begin
      n_fail++;
      $display("FAIL arm_load busy=%0b secs=%0d want 1 2", timer_busy, secs_left);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      n_tests++;
      if (action_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL arm_quiet cycle %0d av=%0b want 0", i, action_valid);
      end
    end
    tick();
    n_tests++;
    if (action !== 3'd4 || action_valid !== 1'b1 || timer_busy !== 1'b0 || secs_left !== '0) begin
      n_fail++;
      $display("FAIL wait20 act=%0d av=%0b busy=%0b secs=%0d want 4 1 0 0",
               action, action_valid, timer_busy, secs_left);
    end
    tick();
    n_tests++;
    if (action_valid !== 1'b0 || action !== 3'd7) begin
      n_fail++;
      $display("FAIL wait20_single act=%0d av=%0b want 7 0", action, action_valid);
    end
  endtask

  task automatic test_alarm_phases();
    issue_cmd(2'd1);
    tick();
    n_tests++;
    if (secs_left !== 9'd3 || timer_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sound_load secs=%0d busy=%0b want 3 1", secs_left, timer_busy);
    end
    for (int k = 1; k <= 3; k++) begin
      repeat (4) tick();
      n_tests++;
      if (secs_left !== SEC_W'(3 - k)) begin
        n_fail++;
        $display("FAIL sound_count step %0d secs=%0d want %0d", k, secs_left, 3 - k);
      end
    end
    n_tests++;
    if (action !== 3'd5 || action_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wait30 act=%0d av=%0b want 5 1", action, action_valid);
    end
    tick();
    tick();
    n_tests++;
    if (secs_left !== 9'd5 || timer_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flash_load secs=%0d busy=%0b want 5 1", secs_left, timer_busy);
    end
    for (int k = 1; k <= 5; k++) begin
      repeat (4) tick();
      n_tests++;
      if (secs_left !== SEC_W'(5 - k)) begin
        n_fail++;
        $display("FAIL flash_count step %0d secs=%0d want %0d", k, secs_left, 5 - k);
      end
    end
    n_tests++;
    if (action !== 3'd6 || action_valid !== 1'b1 || timer_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait270 act=%0d av=%0b busy=%0b want 6 1 0", action, action_valid, timer_busy);
    end
    tick();
  endtask

  task automatic test_cmd_beats_expiry();
    issue_cmd(2'd3);
    issue_cmd(2'd2);
    tick();
    repeat (7) tick();
    cmd_valid = 1'b1;
    cmd       = 2'd2;
    tick();
    n_tests++;
    if (action !== 3'd2 || action_valid !== 1'b1 || timer_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_cmd act=%0d av=%0b busy=%0b want 2 1 0", action, action_valid, timer_busy);
    end
    cmd_valid = 1'b0;
    tick();
    n_tests++;
    if (action !== 3'd7 || action_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_gap act=%0d av=%0b want 7 0", action, action_valid);
    end
    tick();
    n_tests++;
    if (action !== 3'd4 || action_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_pending act=%0d av=%0b want 4 1", action, action_valid);
    end
    tick();
  endtask

  task automatic test_unlock_abort();
    issue_cmd(2'd3);
    issue_cmd(2'd2);
    tick();
    repeat (5) tick();
    cmd_valid = 1'b1;
    cmd       = 2'd3;
    tick();
    n_tests++;
    if (action !== 3'd3 || action_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_unlock act=%0d av=%0b want 3 1", action, action_valid);
    end
    cmd_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if (timer_busy !== 1'b0 || secs_left !== '0 || action_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop busy=%0b secs=%0d av=%0b want 0 0 0", timer_busy, secs_left, action_valid);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (action_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_wait cycle %0d act=%0d av=%0b want no action", i, action, action_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_idle rdy=%0b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd       = 2'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (action_valid !== ((i % 2) == 0) || cmd_ready !== ((i % 2) != 0)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d av=%0b rdy=%0b want %0b %0b",
                 i, action_valid, cmd_ready, (i % 2) == 0, (i % 2) != 0);
      end
    end
    cmd_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_phase();
    issue_cmd(2'd0);
    issue_cmd(2'd2);
    tick();
    repeat (4) tick();
    n_tests++;
    if (secs_left !== 9'd1 || timer_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre secs=%0d busy=%0b want 1 1", secs_left, timer_busy);
    end
    #1;
    rst       = 1'b1;
    fsm_state = 3'd0;
    #1;
    n_tests++;
    if ({action, action_valid, cmd_ready, timer_busy} !== {3'd7, 1'b0, 1'b1, 1'b0} || secs_left !== '0) begin
      n_fail++;
      $display("FAIL midrst_async act=%0d av=%0b rdy=%0b busy=%0b secs=%0d want 7 0 1 0 0",
               action, action_valid, cmd_ready, timer_busy, secs_left);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (action_valid !== 1'b0 || timer_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet cycle %0d av=%0b busy=%0b want 0 0", i, action_valid, timer_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_close_lock_arm();
    test_alarm_phases();
    test_cmd_beats_expiry();
    test_unlock_abort();
    test_back_to_back();
    test_reset_mid_phase();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
